// File: rtl/deser_pkg.sv
// deser_pkg: definitions shared by the 1-to-8 word deserializer.
//   state_e    : frame state. FILL collects words, HOLD presents a frame.
//   NSLOTS     : number of word slots in a frame.
//   SLOT_W     : width of a slot index.
//   words_held : word count in a frame, including a word accepted this cycle.
package deser_pkg;

  localparam int NSLOTS = 8;
  localparam int SLOT_W = 3;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  // The result is 4 bits so that a full frame (7 + 1) reads as 8.
  function automatic logic [3:0] words_held(input logic [SLOT_W-1:0] cnt,
                                            input logic              acc);
    return {1'b0, cnt} + {3'b000, acc};
  endfunction

endpackage

// File: rtl/deser8_wdec.sv
// deser8_wdec: 3-to-8 one-hot slot write-enable decoder.
//   idx_i : slot index to write
//   en_i  : write enable (the accept strobe); all outputs are low when it is low
//   we_o  : one-hot write enable per slot
module deser8_wdec
  import deser_pkg::*;
(
  input  logic [SLOT_W-1:0] idx_i,
  input  logic              en_i,
  output logic [NSLOTS-1:0] we_o
);

  always_comb begin
    we_o = '0;
    if (en_i) we_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/deser8.sv
// deser8: 1-to-8 word deserializer.
// Words from a valid/ready stream fill slots 0..7 in arrival order. The
// complete frame is then presented on out0..out7 under its own valid/ready
// handshake.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous reset, active low
//   in_data    : incoming word (SIZE bits)
//   in_valid   : in_data is valid
//   in_ready   : the block accepts in_data this cycle
//   out0..out7 : frame slots; out0 holds the first word received
//   out_valid  : a frame is being presented
//   out_ready  : the consumer takes the frame this cycle
//   flush      : closes a partial frame (only when DESER8_FLUSH_EN is defined)
//   out_cnt    : number of valid words in the frame, 1..8 (only when DESER8_FLUSH_EN is defined)
//
// Build option: defining DESER8_FLUSH_EN adds the flush/out_cnt ports.
// With it, a flushed frame reads 0 in every slot it did not fill.
//
// state | meaning
// FILL  | collecting words; in_ready high
// HOLD  | frame presented; in_ready follows out_ready
module deser8
  import deser_pkg::*;
#(
  parameter int SIZE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SIZE-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [SIZE-1:0] out0,
  output logic [SIZE-1:0] out1,
  output logic [SIZE-1:0] out2,
  output logic [SIZE-1:0] out3,
  output logic [SIZE-1:0] out4,
  output logic [SIZE-1:0] out5,
  output logic [SIZE-1:0] out6,
  output logic [SIZE-1:0] out7,
  output logic            out_valid,
  input  logic            out_ready
`ifdef DESER8_FLUSH_EN
  ,
  input  logic            flush,
  output logic [3:0]      out_cnt
`endif
);

  state_e            state_q, state_d;
  logic [SLOT_W-1:0] cnt_q, cnt_d;
  logic [SIZE-1:0]   slot_q [NSLOTS];

  logic              accept;
  logic              take;
  logic              last_word;
  logic [SLOT_W-1:0] wr_idx;
  logic [NSLOTS-1:0] slot_we;

  // in_ready is low while reset is asserted, so nothing is consumed during reset.
  assign in_ready  = rst_n & ((state_q == FILL) | out_ready);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid & in_ready;
  assign take      = out_valid & out_ready;
  assign last_word = (state_q == FILL) & accept & (cnt_q == SLOT_W'(NSLOTS - 1));

  // Accepting in HOLD only happens together with a take. That word
  // starts the next frame, so it goes to slot 0.
  assign wr_idx = (state_q == HOLD) ? '0 : cnt_q;

  deser8_wdec u_wdec (
    .idx_i (wr_idx),
    .en_i  (accept),
    .we_o  (slot_we)
  );

`ifdef DESER8_FLUSH_EN
  logic       do_flush;
  logic [3:0] n_words;
  logic [3:0] out_cnt_q;

  // A flush is ignored on an empty frame and while a frame is being presented.
  assign n_words  = words_held(cnt_q, accept);
  assign do_flush = (state_q == FILL) & flush & ((cnt_q != '0) | accept);
  assign out_cnt  = out_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt_q <= '0;
    end else if (do_flush) begin
      out_cnt_q <= n_words;
    end else if (last_word) begin
      out_cnt_q <= 4'd8;
    end else if (take) begin
      out_cnt_q <= '0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      FILL: begin
        if (accept) cnt_d = cnt_q + SLOT_W'(1);  // 7 -> 0 only on the last word
        if (last_word) state_d = HOLD;
`ifdef DESER8_FLUSH_EN
        if (do_flush) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
`endif
      end
      HOLD: begin
        if (take) begin
          state_d = FILL;
          cnt_d   = accept ? SLOT_W'(1) : '0;
        end
      end
      default: begin
        state_d = FILL;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSLOTS; i++) slot_q[i] <= '0;
    end else begin
      for (int i = 0; i < NSLOTS; i++) begin
        if (slot_we[i]) begin
          slot_q[i] <= in_data;
`ifdef DESER8_FLUSH_EN
        end else if (do_flush && (4'(i) >= n_words)) begin
          // Slots past the flushed word count would otherwise show words from an earlier frame.
          slot_q[i] <= '0;
`endif
        end
      end
    end
  end

  assign out0 = slot_q[0];
  assign out1 = slot_q[1];
  assign out2 = slot_q[2];
  assign out3 = slot_q[3];
  assign out4 = slot_q[4];
  assign out5 = slot_q[5];
  assign out6 = slot_q[6];
  assign out7 = slot_q[7];

endmodule

// File: tb/tb_deser8.sv
module tb_deser8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out0, out1, out2, out3, out4, out5, out6, out7;
  logic       out_valid;
  logic       out_ready;
  logic       flush_s;
`ifdef DESER8_FLUSH_EN
  logic [3:0] out_cnt;
`endif

  always #5 clk = ~clk;

  deser8 #(.SIZE(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out4      (out4),
    .out5      (out5),
    .out6      (out6),
    .out7      (out7),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef DESER8_FLUSH_EN
    ,
    .flush     (flush_s),
    .out_cnt   (out_cnt)
`endif
  );

  logic [7:0] dout [8];
  assign dout[0] = out0;
  assign dout[1] = out1;
  assign dout[2] = out2;
  assign dout[3] = out3;
  assign dout[4] = out4;
  assign dout[5] = out5;
  assign dout[6] = out6;
  assign dout[7] = out7;

  // Reference model. pend holds the words of the frame being collected,
  // in arrival order. frame holds the frame being presented.
  logic       holding;
  logic [7:0] pend [$];
  logic [7:0] frame [8];
  int         n_held;
  int         frames_taken;
  logic       last_acc;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    holding = 1'b0;
    pend.delete();
    n_held = 0;
  endtask

  // One cycle: drive the inputs, compare the DUT against the model, then
  // apply the clock edge to the model.
  task automatic step(input logic v, input logic [7:0] d, input logic r, input logic f);
    logic exp_ir;
    logic acc;
    logic tk;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush_s   = f;
    #1;
    exp_ir = holding ? r : 1'b1;
    chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ir});
    chk("out_valid", {31'b0, out_valid}, {31'b0, holding});
    if (holding) begin
      for (int i = 0; i < 8; i++) chk($sformatf("slot%0d", i), {24'b0, dout[i]}, {24'b0, frame[i]});
`ifdef DESER8_FLUSH_EN
      chk("out_cnt", {28'b0, out_cnt}, n_held);
`endif
    end
    @(posedge clk);
    acc = v & exp_ir;
    tk  = holding & r;
    last_acc = acc;
    if (holding) begin
      if (tk) begin
        holding = 1'b0;
        frames_taken++;
        pend.delete();
        if (acc) pend.push_back(d);
      end
    end else begin
      if (acc) pend.push_back(d);
      if (pend.size() == 8) begin
        for (int i = 0; i < 8; i++) frame[i] = pend[i];
        n_held  = 8;
        holding = 1'b1;
        pend.delete();
      end
`ifdef DESER8_FLUSH_EN
      else if (f && pend.size() > 0) begin
        for (int i = 0; i < 8; i++) frame[i] = (i < pend.size()) ? pend[i] : 8'h00;
        n_held  = pend.size();
        holding = 1'b1;
        pend.delete();
      end
`endif
    end
  endtask

  // Asserts reset asynchronously, between clock edges, while offering a word.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h77;
    out_ready = 1'b1;
    flush_s   = 1'b0;
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    for (int i = 0; i < 8; i++) chk($sformatf("rst_slot%0d", i), {24'b0, dout[i]}, 32'd0);
`ifdef DESER8_FLUSH_EN
    chk("rst_out_cnt", {28'b0, out_cnt}, 32'd0);
`endif
    model_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
  endtask

  initial begin
    int         base;
    int         guard;
    logic [7:0] w;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush_s = 1'b0;
    frames_taken = 0;
    last_acc = 1'b0;
    model_reset();
    do_reset();

    // Full frame 0x10..0x17, sent back to back.
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h10 + i), 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("full_valid", {31'b0, out_valid}, 32'd1);
    chk("full_out0", {24'b0, out0}, 32'h10);
    chk("full_out7", {24'b0, out7}, 32'h17);

    // Backpressure: a word is offered but must not be consumed.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'h55, 1'b0, 1'b0);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    chk("bp_out3", {24'b0, out3}, 32'h13);

    // Take and accept in the same cycle, then 7 more words at full rate.
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h20 + i), 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("simul_out0", {24'b0, out0}, 32'hAA);
    chk("simul_out1", {24'b0, out1}, 32'h20);
    chk("simul_out7", {24'b0, out7}, 32'h26);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Reset after 5 accepted words: the partial frame is discarded.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b1, 1'b0);
    do_reset();
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("post_rst_out0", {24'b0, out0}, 32'h40);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Random data, gaps and backpressure over at least 4 frames. The
    // producer holds each word until it is accepted.
    base  = frames_taken;
    guard = 0;
    while (frames_taken < base + 4 && guard < 3000) begin
      repeat ($urandom_range(0, 3)) begin
        step(1'b0, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        guard++;
      end
      w = 8'($urandom);
      do begin
        step(1'b1, w, 1'($urandom_range(0, 1)), 1'b0);
        guard++;
      end while (!last_acc && guard < 3000);
    end
    chk("rand_frames_done", {31'b0, (frames_taken >= base + 4)}, 32'd1);

`ifdef DESER8_FLUSH_EN
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h01 + i), 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("flush_cnt", {28'b0, out_cnt}, 32'd3);
    chk("flush_out2", {24'b0, out2}, 32'h03);
    chk("flush_out3", {24'b0, out3}, 32'h00);
    chk("flush_out7", {24'b0, out7}, 32'h00);
    step(1'b0, 8'h00, 1'b1, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
